// File: rtl/time_of_day_counter.sv
// 24-hour time-of-day counter: divides clk to a 1 Hz tick and keeps HH:MM:SS as BCD digits,
// with hour/minute set pulses, a registered second tick and a 1 Hz colon blink.
module time_of_day_counter #(
   parameter int CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       inc_min,
   input  logic       inc_hr,
   output logic [3:0] h2,
   output logic [3:0] h1,
   output logic [3:0] m2,
   output logic [3:0] m1,
   output logic [3:0] s2,
   output logic [3:0] s1,
   output logic       sec_tick,
   output logic       colon
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

   // Two-digit BCD increment that wraps to 00 after the given last value.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] last);
      logic [7:0] r;
      if (v == last) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   logic [PW-1:0] presc_r, presc_s;
   logic [7:0]    sec_r, sec_s;
   logic [7:0]    min_r, min_s;
   logic [7:0]    hr_r, hr_s;
   logic          sec_tick_r, sec_tick_s;
   logic          tick_s, sec_wrap_s, min_wrap_s;

   // Next-state: prescaler, BCD carry chain and the set-pulse overrides.
   always_comb begin
      presc_s    = presc_r;
      sec_s      = sec_r;
      min_s      = min_r;
      hr_s       = hr_r;
      sec_tick_s = 1'b0;
      tick_s     = run && (presc_r == PRE_MAX);
      sec_wrap_s = tick_s && (sec_r == 8'h59);
      min_wrap_s = sec_wrap_s && (min_r == 8'h59);

      // A minute set restarts the second and swallows any tick on the same edge.
      if (inc_min) begin
         presc_s = {PW{1'b0}};
         sec_s   = 8'h00;
         min_s   = bcd2_inc(min_r, 8'h59);
      end else begin
         if (tick_s) begin
            presc_s    = {PW{1'b0}};
            sec_s      = bcd2_inc(sec_r, 8'h59);
            sec_tick_s = 1'b1;
         end else if (run) begin
            presc_s = presc_r + PW'(1);
         end else begin
            presc_s = presc_r;
         end
         if (sec_wrap_s) begin
            min_s = bcd2_inc(min_r, 8'h59);
         end else begin
            min_s = min_r;
         end
      end

      // An hour set absorbs a same-edge hour carry so hours move by exactly one.
      if (inc_hr) begin
         hr_s = bcd2_inc(hr_r, 8'h23);
      end else if (min_wrap_s && !inc_min) begin
         hr_s = bcd2_inc(hr_r, 8'h23);
      end else begin
         hr_s = hr_r;
      end
   end

   // State register with asynchronous reset to 00:00:00.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r    <= {PW{1'b0}};
         sec_r      <= 8'h00;
         min_r      <= 8'h00;
         hr_r       <= 8'h00;
         sec_tick_r <= 1'b0;
      end else begin
         presc_r    <= presc_s;
         sec_r      <= sec_s;
         min_r      <= min_s;
         hr_r       <= hr_s;
         sec_tick_r <= sec_tick_s;
      end
   end

   assign h2       = hr_r[7:4];
   assign h1       = hr_r[3:0];
   assign m2       = min_r[7:4];
   assign m1       = min_r[3:0];
   assign s2       = sec_r[7:4];
   assign s1       = sec_r[3:0];
   assign sec_tick = sec_tick_r;
   assign colon    = !run || (presc_r < PRE_HALF);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench: a seconds-of-day model is compared against the DUT every cycle,
// with directed scenarios pinned by literal HHMMSS expectations and a randomized phase.
module tb_time_of_day_counter;
   localparam int CLK_HZ = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic inc_min = 1'b0;
   logic inc_hr = 1'b0;
   logic [3:0] h2, h1, m2, m1, s2, s1;
   logic sec_tick, colon;

   int checks = 0;
   int errors = 0;

   int mt = 0;     // model time in seconds of day
   int mp = 0;     // model prescaler
   bit mtick = 1'b0;
   int mh, mms;
   bit mtk;

   time_of_day_counter #(.CLK_HZ(CLK_HZ)) dut (
      .clk(clk), .rst(rst), .run(run), .inc_min(inc_min), .inc_hr(inc_hr),
      .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
      .sec_tick(sec_tick), .colon(colon)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] dut_digits();
      return {h2, h1, m2, m1, s2, s1};
   endfunction

   // Behavioural model: time as seconds of day, split into hours and minute-second part.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mt = 0; mp = 0; mtick = 1'b0;
      end else begin
         mh = mt / 3600;
         mms = mt % 3600;
         mtk = run && (mp == CLK_HZ - 1);
         mtick = 1'b0;
         if (inc_min) begin
            mms = (((mms / 60) + 1) % 60) * 60;
            mp = 0;
         end else begin
            if (run) mp = (mp + 1) % CLK_HZ;
            if (mtk) begin
               mtick = 1'b1;
               if (mms == 3599 && !inc_hr) mh = (mh + 1) % 24;
               mms = (mms + 1) % 3600;
            end
         end
         if (inc_hr) mh = (mh + 1) % 24;
         mt = mh * 3600 + mms;
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [25:0] got, exp;
      got = {dut_digits(), sec_tick, colon};
      exp = {to_bcd(mt), mtick, (!run || (mp < CLK_HZ / 2))};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cycle_compare @%0t: got %h expected %h", $time, got, exp);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_min();
      inc_min = 1'b1; step(1); inc_min = 1'b0;
   endtask

   task automatic pulse_hr();
      inc_hr = 1'b1; step(1); inc_hr = 1'b0;
   endtask

   task automatic set_hours(input int h);
      for (int i = 0; i < 30 && (mt / 3600) != h; i++) pulse_hr();
   endtask

   task automatic set_minutes(input int m);
      for (int i = 0; i < 70 && ((mt / 60) % 60) != m; i++) pulse_min();
   endtask

   initial begin
      // Reset state
      step(2);
      chk("reset_digits", dut_digits(), 24'h000000);
      chk("reset_tick", sec_tick, 1'b0);
      chk("reset_colon", colon, 1'b1);
      run = 1'b1; rst = 1'b0;
      step(9);
      chk("first_tick_not_early", {dut_digits(), sec_tick}, {24'h000000, 1'b0});
      step(1);
      chk("first_tick", {dut_digits(), sec_tick}, {24'h000001, 1'b1});

      // Seconds carry into minutes
      step(580);
      chk("at_59s", dut_digits(), 24'h000059);
      step(10);
      chk("sec_carry", {dut_digits(), sec_tick}, {24'h000100, 1'b1});

      // Full-day wrap
      set_hours(23);
      set_minutes(59);
      step(590);
      chk("at_235959", dut_digits(), 24'h235959);
      step(10);
      chk("day_wrap", {dut_digits(), sec_tick}, {24'h000000, 1'b1});

      // Minute set at 09:59:xx clears seconds and restarts the prescaler
      set_hours(9);
      set_minutes(59);
      step(37);
      chk("at_095903", dut_digits(), 24'h095903);
      pulse_min();
      chk("inc_min_wrap", {dut_digits(), sec_tick}, {24'h090000, 1'b0});
      step(9);
      chk("prescaler_restart_wait", sec_tick, 1'b0);
      step(1);
      chk("prescaler_restart_tick", {dut_digits(), sec_tick}, {24'h090001, 1'b1});
      set_hours(23);
      pulse_hr();
      chk("inc_hr_wrap", {h2, h1}, 8'h00);

      // Hour set on the same edge as an hour carry
      set_hours(12);
      set_minutes(59);
      step(590);
      chk("at_125959", dut_digits(), 24'h125959);
      step(9);
      pulse_hr();
      chk("inc_hr_on_carry", {dut_digits(), sec_tick}, {24'h130000, 1'b1});

      // Minute set on a tick edge
      set_hours(12);
      set_minutes(58);
      step(590);
      chk("at_125859", dut_digits(), 24'h125859);
      step(9);
      pulse_min();
      chk("inc_min_on_tick", {dut_digits(), sec_tick}, {24'h125900, 1'b0});

      // Freeze with run=0; a held pulse increments once per cycle
      step(3);
      run = 1'b0;
      step(10);
      chk("frozen_colon", colon, 1'b1);
      inc_min = 1'b1; step(3); inc_min = 1'b0;
      chk("held_inc_min", {m2, m1}, 8'h02);
      step(12);
      run = 1'b1;
      step(25);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         run = ($urandom_range(0, 9) != 0);
         inc_min = ($urandom_range(0, 29) == 0);
         inc_hr = ($urandom_range(0, 39) == 0);
         step(1);
      end
      run = 1'b1; inc_min = 1'b0; inc_hr = 1'b0;

      // Asynchronous reset mid-second
      rst = 1'b1; step(1); rst = 1'b0;
      set_hours(5);
      set_minutes(43);
      step(210);
      chk("at_054321", dut_digits(), 24'h054321);
      step(4);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {dut_digits(), sec_tick, colon}, {24'h000000, 1'b0, 1'b1});
      @(posedge clk);
      #1 rst = 1'b0;
      step(9);
      chk("post_reset_wait", sec_tick, 1'b0);
      step(1);
      chk("post_reset_tick", {dut_digits(), sec_tick}, {24'h000001, 1'b1});
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Upstream timekeeping stage for the four-digit HH:MM clock display.
- Divides the board clock down to 1 Hz and maintains a 24-hour time as BCD digits h2 h1 : m2 m1, plus seconds s2 s1.
- Each BCD digit drives one 7-segment decoder instance downstream.
- Provides hour/minute set pulses, a one-cycle second tick and a colon-blink signal.

Parameters:
CLK_HZ, 50000000, input clock frequency; one second = exactly CLK_HZ clk cycles (minimum 4, even).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = time advances; 0 = prescaler frozen, no second ticks
inc_min  in  1  single-cycle pulse, synchronous to clk; advance minutes by 1
inc_hr  in  1  single-cycle pulse, synchronous to clk; advance hours by 1
h2  out  4  hours tens, BCD 0..2
h1  out  4  hours units, BCD 0..9 (0..3 when h2=2)
m2  out  4  minutes tens, BCD 0..5
m1  out  4  minutes units, BCD 0..9
s2  out  4  seconds tens, BCD 0..5
s1  out  4  seconds units, BCD 0..9
sec_tick  out  1  high exactly one cycle, in the cycle the seconds value advances
colon  out  1  colon enable for display

Behaviour:
- Reset (rst=1, asynchronous):
  - prescaler = 0.
  - All digits = 0, i.e. time 00:00:00.
  - sec_tick = 0; colon = 1.
  - Reset asserted mid-count discards the partial second.
- Prescaler:
  - Counter width is ceil(log2(CLK_HZ)) bits.
  - While run=1, counts 0..CLK_HZ-1.
  - On the edge where it equals CLK_HZ-1, it returns to 0 and a second tick occurs.
  - While run=0, it holds its value.
- Tick edge, all registered in the same edge:
  - s1/s2 increment with BCD carry; s1 9->0 carries into s2.
  - 59 s -> 00 s carries into minutes; 59 min -> 00 min carries into hours; 23 h -> 00 h wraps with no further carry.
  - sec_tick is registered: high the cycle after the tick edge, together with the new digit values.
- No digit ever holds a non-BCD value or exceeds its range: no 24:xx, no 60.
- inc_min pulse:
  - minutes +1 mod 60, with no carry into hours.
  - s1, s2 and the prescaler are cleared to 0 on that edge.
  - Any tick on the same edge is discarded; sec_tick stays 0.
  - Any minute carry from that tick is dropped, so minutes advance by exactly 1.
- inc_hr pulse:
  - hours +1 mod 24; minutes and seconds unaffected by the pulse itself.
  - If a tick on the same edge would carry into hours, the carry is dropped, so hours advance by exactly 1.
  - The seconds/minutes part of that tick still applies.
- inc_min and inc_hr on the same edge: both apply independently, as above.
- Set pulses act regardless of run.
- A pulse held high N cycles increments N times; the block performs no edge detection.
- colon = 1 when run=0 or prescaler < CLK_HZ/2, else 0. It is combinational from registered state, giving a 50% blink at 1 Hz with the colon on at the start of each second.
- Latency:
  - Set pulse to updated digit: 1 cycle.
  - Reset release to first sec_tick: CLK_HZ cycles (run held 1).

Test Plan (CLK_HZ=10):
- Reset, run=1 for 10 cycles -> one sec_tick pulse one cycle wide; s1=1 visible with it; colon high 5 cycles then low 5.
- Run to 00:00:59, next tick -> s2:s1=00, m1=1 with sec_tick; then drive time to 23:59:59, tick -> 00:00:00 with no invalid intermediate value.
- At 09:59:xx pulse inc_min -> 09:00:00, hours unchanged, prescaler restarted (next tick exactly 10 cycles later); inc_hr at 23:xx -> 00:xx.
- At 12:59:59, pulse inc_hr on the same edge as the tick -> 13:00:00 (hour +1 once, not 14). At 12:58:59, pulse inc_min on the tick edge -> 12:59:00, sec_tick stays 0.
- run=0 for 25 cycles -> digits and prescaler frozen, colon=1, no sec_tick; inc_min still advances minutes. run=1 resumes the count from the frozen prescaler value.
- Assert rst asynchronously mid-second at 05:43:21 -> outputs reach 00:00:00, sec_tick=0 and colon=1 before the next clk edge; after release, first tick after 10 cycles.
